display_scan_ctrl: RTL
======================

// Module: display_scan_ctrl
// PURPOSE
//  Sequences the 2-digit seven-segment display behind control_BCD.
//  - Generates the units/tens scan order and drives control_BCD's digit-select input.
//  - Drives the active-low anodes, with a blanking gap between digits to prevent ghosting.
//  - Double-buffers the binary value so it only changes at frame start (no tearing).
//  - Sits between the Gray-to-binary converter and control_BCD/segment decoder.
// PARAMETERS
//  CLK_DIV    10000  clock cycles per digit slot (show + blank); 100 MHz -> 10 kHz
//  BLANK_CYC  100    cycles of each slot spent blanked; 1 <= BLANK_CYC < CLK_DIV (elab error otherwise)
//  LZ_BLANK   1      1: tens digit dark when held value < 10; 0: tens shows '0'
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  bin_in     in   4  binary value from Gray converter (0..15)
//  bin_load   in   1  1-cycle strobe: capture bin_in into pending buffer
//  bin_hold   out  4  committed value, feeds control_BCD bin
//  digit_sel  out  1  0 = units, 1 = tens; feeds control_BCD digit select
//  an         out  4  anodes, active-low; an[0] units, an[1] tens, an[3:2] always 1
//  blank      out  1  1 = force segments off
//  frame_tick out  1  1-cycle pulse at every frame start
//  upd_ack    out  1  1-cycle pulse when a pending value is committed
// BEHAVIOUR
//  - FSM states: BLANK_T -> SHOW_U -> BLANK_U -> SHOW_T -> BLANK_T ...
//    - SHOW states last CLK_DIV-BLANK_CYC cycles; BLANK states last BLANK_CYC cycles.
//    - Frame = 2*CLK_DIV cycles.
//  - Counter cnt ($clog2(CLK_DIV) bits) counts cycles in the current state.
//    - When cnt == duration-1: state advances and cnt <= 0.
//  - All outputs are registered and update on the same edge as the state.
//    - SHOW_U:  an=1110, blank=0, digit_sel=0.
//    - BLANK_U: an=1111, blank=1, digit_sel=1.
//    - SHOW_T:  an=1101, blank=0, digit_sel=1.
//    - BLANK_T: an=1111, blank=1, digit_sel=0.
//    - digit_sel changes at blank entry, so control_BCD output settles while dark.
//  - Leading zeros: if LZ_BLANK=1 and bin_hold<10, SHOW_T outputs an=1111, blank=1.
//  - Load: bin_load=1 -> pending<=bin_in, pend_v<=1.
//    - A later load in the same frame overwrites pending; last value wins.
//  - Commit: on the BLANK_T->SHOW_U edge:
//    - frame_tick=1 (every frame).
//    - If pend_v: bin_hold<=pending, pend_v<=0, upd_ack=1.
//    - If bin_load is on the same edge: commit uses the pre-edge pending; the new
//      bin_in goes to pending and pend_v stays 1, so it commits next frame.
//  - Latency: bin_load -> bin_hold is 1..2*CLK_DIV cycles.
//  - Reset values: state=BLANK_T, cnt=0, bin_hold=0, pending=0, pend_v=0,
//    digit_sel=0, an=1111, blank=1, frame_tick=0, upd_ack=0.
//  - rst dominates every other input at any state; a pending value is discarded.
//    - First SHOW_U (with frame_tick) is entered BLANK_CYC cycles after rst falls.
// TESTING (CLK_DIV=8, BLANK_CYC=2, LZ_BLANK=1; frame = 16 cycles)
//  1. rst high 3 cycles, then low -> an=1111/blank=1 for 2 cycles, then an=1110 and frame_tick=1;
//     an=1110 held 6 cycles; bin_hold=0.
//  2. bin_load with bin_in=7 during SHOW_T -> bin_hold=7 and upd_ack=1 at next SHOW_U entry;
//     in SHOW_T, an=1111 and blank=1 (leading zero blanked).
//  3. Load 12 -> after commit, SHOW_U an=1110 and SHOW_T an=1101 with blank=0, digit_sel=1;
//     digit_sel toggles 2 cycles before each show.
//  4. Loads 3 then 9 within one frame -> exactly one upd_ack; bin_hold goes 0->9, never 3.
//  5. Pending=5 and bin_load(bin_in=11) on the commit edge -> bin_hold=5 now, 11 at the
//     next frame start, with one upd_ack per frame.
//  6. rst pulsed mid-SHOW_T with a pending load -> reset values next cycle; pending lost;
//     no upd_ack in the following frame.

Source files
------------

// File: rtl/display_scan_if.sv
// display_scan_if: value-load inputs and scan/anode outputs of the display scan controller
interface display_scan_if;
  logic [3:0] bin_in;
  logic       bin_load;
  logic [3:0] bin_hold;
  logic       digit_sel;
  logic [3:0] an;
  logic       blank;
  logic       frame_tick;
  logic       upd_ack;
  modport master (output bin_in, bin_load, input bin_hold, digit_sel, an, blank, frame_tick, upd_ack);
  modport slave  (input bin_in, bin_load, output bin_hold, digit_sel, an, blank, frame_tick, upd_ack);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 2-digit scan sequencer with blanking gaps and frame-synchronous value commit
module display_scan_ctrl #(
  parameter int CLK_DIV   = 10000,
  parameter int BLANK_CYC = 100,
  parameter bit LZ_BLANK  = 1'b1
) (
  input logic clk,
  input logic rst,
  display_scan_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  if (BLANK_CYC < 1 || BLANK_CYC >= CLK_DIV) begin : g_bad_blank
    $error("BLANK_CYC must satisfy 1 <= BLANK_CYC < CLK_DIV");
  end
  typedef enum logic [1:0] {BLANK_T, SHOW_U, BLANK_U, SHOW_T} state_t;
  state_t ns, state;
  logic [CW-1:0] cnt;
  logic [3:0] pending;
  logic pend_v, last, commit, lz, show_u, show_t;
  always_comb begin
    last = cnt == ((state == SHOW_U || state == SHOW_T) ? CW'(CLK_DIV - BLANK_CYC - 1) : CW'(BLANK_CYC - 1));
    ns = last ? state_t'(state + 2'd1) : state;
    commit = last && state == BLANK_T;
    lz = LZ_BLANK && bus.bin_hold < 4'd10;
    show_u = ns == SHOW_U;
    show_t = ns == SHOW_T && !lz;
  end
  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK_T;
      cnt <= '0;
      pending <= '0;
      pend_v <= 1'b0;
      bus.bin_hold <= '0;
      bus.digit_sel <= 1'b0;
      bus.an <= 4'b1111;
      bus.blank <= 1'b1;
      bus.frame_tick <= 1'b0;
      bus.upd_ack <= 1'b0;
    end else begin
      state <= ns;
      cnt <= last ? '0 : cnt + 1'b1;
      bus.frame_tick <= commit;
      bus.upd_ack <= commit && pend_v;
      if (commit && pend_v) begin
        bus.bin_hold <= pending;
        pend_v <= 1'b0;
      end
      // a load on the commit edge refills pending after the old value was taken
      if (bus.bin_load) begin
        pending <= bus.bin_in;
        pend_v <= 1'b1;
      end
      bus.an <= show_u ? 4'b1110 : show_t ? 4'b1101 : 4'b1111;
      bus.blank <= !(show_u || show_t);
      bus.digit_sel <= ns == BLANK_U || ns == SHOW_T;
    end
  end
endmodule
